walk_sched: RTL

- Wishbone bus master that shares the single LED-walker peripheral between NREQ independent requesters, e.g. buttons or UART commands.
- Each requester issues single-cycle request pulses. These are counted per requester, granted round-robin, and issued to the walker as one Wishbone write per walk.
- Optionally, the block polls the walker status until the walk finishes before it grants the next requester.

---
 rtl/walk_sched_if.sv | 21 ++
 rtl/walk_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/walk_sched_if.sv
// rtl/walk_sched_if.sv - Wishbone bus between walk_sched and the LED-walker peripheral
interface walk_sched_if;
    logic        o_cyc;
    logic        o_stb;
    logic        o_we;
    logic        o_addr;
    logic [31:0] o_data;
    logic        i_stall;
    logic        i_ack;
    logic [31:0] i_data;

    modport master (
        output o_cyc, o_stb, o_we, o_addr, o_data,
        input  i_stall, i_ack, i_data
    );

    modport slave (
        input  o_cyc, o_stb, o_we, o_addr, o_data,
        output i_stall, i_ack, i_data
    );
endinterface

// File: rtl/walk_sched.sv
// rtl/walk_sched.sv - round-robin Wishbone scheduler sharing one LED walker; optional status polling under WALK_SCHED_POLL_EN
module walk_sched #(
    parameter int NREQ    = 4,
    parameter int CW      = 3,
    parameter int TIMEOUT = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [NREQ-1:0] i_req,
    walk_sched_if.master    wb,
    output logic            o_busy,
    output logic [2:0]      o_grant,
    output logic [NREQ-1:0] o_overflow,
    output logic            o_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WACK, S_RD, S_RACK, S_DONE
    } state_t;

    state_t          state_q;
    logic            cyc_q, stb_q, we_q, busy_q, err_q;
    logic [31:0]     data_q;
    logic [2:0]      grant_q, ptr_q;
    logic [TW-1:0]   tmo_q;
    logic [CW-1:0]   cnt_q [NREQ];
    logic [NREQ-1:0] ovf_q;

    logic            pick_valid;
    logic [2:0]      pick_id;
    logic            tmo_hit;

    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

    // Round-robin pick: first nonzero counter at or after ptr_q, wrapping
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            for (int k = 0; k < NREQ; k++) begin
                if ((k == ((int'(ptr_q) + i) % NREQ)) && (cnt_q[k] != '0)) begin
                    pick_valid = 1'b1;
                    pick_id    = 3'(k);
                end
            end
        end
    end

    // Pending counters: saturating increment on request, decrement when a grant finishes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (i_req[k] && !((state_q == S_DONE) && (grant_q == 3'(k)))) begin
                    if (cnt_q[k] == CMAX) ovf_q[k] <= 1'b1;
                    else                  cnt_q[k] <= cnt_q[k] + CW'(1);
                end else if (!i_req[k] && (state_q == S_DONE) && (grant_q == 3'(k))) begin
                    if (cnt_q[k] != '0) cnt_q[k] <= cnt_q[k] - CW'(1);
                end
            end
        end
    end

    // Bus master FSM; a timeout aborts the transaction but still consumes the request
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= '0;
            grant_q <= 3'd0;
            ptr_q   <= 3'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        state_q <= S_WR;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        data_q  <= {29'd0, pick_id};
                        grant_q <= pick_id;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                    end
                end
                S_WR: begin
                    if (tmo_hit) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                        if (!wb.i_stall) begin
                            stb_q   <= 1'b0;
                            state_q <= S_WACK;
                        end
                    end
                end
                S_WACK: begin
                    if (wb.i_ack) begin
                        cyc_q <= 1'b0;
`ifdef WALK_SCHED_POLL_EN
                        state_q <= S_RD;
`else
                        state_q <= S_DONE;
`endif
                    end else if (tmo_hit) begin
                        cyc_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
`ifdef WALK_SCHED_POLL_EN
                S_RD: begin
                    // first RD cycle is the idle gap with cyc low; the read starts after it
                    if (!cyc_q) begin
                        cyc_q <= 1'b1;
                        stb_q <= 1'b1;
                        we_q  <= 1'b0;
                        tmo_q <= '0;
                    end else if (tmo_hit) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                        if (!wb.i_stall) begin
                            stb_q   <= 1'b0;
                            state_q <= S_RACK;
                        end
                    end
                end
                S_RACK: begin
                    if (wb.i_ack) begin
                        cyc_q   <= 1'b0;
                        state_q <= (wb.i_data[3:0] == 4'd0) ? S_DONE : S_RD;
                    end else if (tmo_hit) begin
                        cyc_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ptr_q   <= (grant_q == 3'(NREQ - 1)) ? 3'd0 : grant_q + 3'd1;
                end
                default: begin
                    state_q <= S_IDLE;
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef WALK_SCHED_POLL_EN
    logic unused_rdata;
    assign unused_rdata = ^wb.i_data[31:4];
`else
    logic unused_rdata;
    assign unused_rdata = ^wb.i_data;
`endif

    assign wb.o_cyc    = cyc_q;
    assign wb.o_stb    = stb_q;
    assign wb.o_we     = we_q;
    assign wb.o_addr   = 1'b0;
    assign wb.o_data   = data_q;
    assign o_busy      = busy_q;
    assign o_grant     = grant_q;
    assign o_overflow  = ovf_q;
    assign o_err       = err_q;

    a_stb_cyc: assert property (@(posedge i_clk) disable iff (i_reset) wb.o_stb |-> wb.o_cyc);
    a_state_legal: assert property (@(posedge i_clk) disable iff (i_reset)
        state_q inside {S_IDLE, S_WR, S_WACK, S_RD, S_RACK, S_DONE});
    a_stall_stable: assert property (@(posedge i_clk) disable iff (i_reset)
        (wb.o_stb && wb.i_stall && !tmo_hit) |=> (wb.o_stb && $stable(wb.o_we) && $stable(wb.o_data)));

endmodule
